plot_receiver: RTL

- Consumer end of the pixel-plot stream (writeEn, x_out, y_out, color) produced by the rectangle drawers (brick, ball, paddle).
- Clips off-screen plots and converts (x,y) to a linear framebuffer address.
- Buffers accepted plots in a FIFO and drains them to a framebuffer write port that has backpressure.
- Reports idle, so control FSMs can wait on completion instead of a fixed delay count.

---
 rtl/plot_receiver_pkg.sv | 18 +
 rtl/plot_receiver_if.sv | 32 +++
 rtl/plot_receiver_fifo.sv | 57 +++++
 rtl/plot_receiver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/plot_receiver_pkg.sv
// plot_receiver_pkg
//   Shared definitions for the plot receiver slice: default screen geometry,
//   framebuffer address/colour widths, plot coordinate width and the encoding
//   of the drain state machine.
package plot_receiver_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 10;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/plot_receiver_if.sv
// plot_receiver_if
//   Framebuffer write port with backpressure.
//     mem_we    : write valid (master -> slave)
//     mem_addr  : linear framebuffer address (master -> slave)
//     mem_data  : pixel colour (master -> slave)
//     mem_ready : framebuffer accepts the write this cycle (slave -> master)
//   A write completes in every cycle where mem_we and mem_ready are both 1.
interface plot_receiver_if #(
    parameter int ADDR_W  = plot_receiver_pkg::ADDR_W,
    parameter int COLOR_W = plot_receiver_pkg::COLOR_W
) ();

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [COLOR_W-1:0] mem_data;
    logic               mem_ready;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_data,
        input  mem_ready
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_data,
        output mem_ready
    );

endinterface

// File: rtl/plot_receiver_fifo.sv
// plot_fifo
//   Synchronous show-ahead FIFO: dout always presents the head entry while
//   empty is 0. Pointers carry one extra wrap bit to tell full from empty.
//   Ports:
//     clk, resetn : clock, asynchronous active-low reset (pointers only)
//     push, din   : write request and data (ignored when full unless popping)
//     pop         : remove head (ignored when empty)
//     dout        : head entry
//     empty, full : occupancy flags
module plot_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // At full a push may land in the slot being popped: the head has already
    // been consumed from dout this cycle, so overwriting it is safe.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/plot_receiver.sv
// plot_receiver
//   Consumer end of the drawer pixel-plot stream. Clips off-screen plots,
//   converts (x,y) to a linear framebuffer address, buffers plots in a FIFO
//   and drains them to a framebuffer write port with backpressure.
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     writeEn              : plot strobe (drawer cannot be stalled)
//     x_in, y_in, color_in : plot coordinates and colour
//     clr_status           : synchronous clear of overflow and drop_count
//     mem                  : framebuffer write port (master side)
//     idle                 : nothing in the input stage or the FIFO
//     overflow             : sticky, a plot was lost to a full FIFO
//     drop_count           : saturating count of clipped + lost plots
module plot_receiver #(
    parameter int SCREEN_W = plot_receiver_pkg::SCREEN_W,
    parameter int SCREEN_H = plot_receiver_pkg::SCREEN_H,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = plot_receiver_pkg::ADDR_W,
    parameter int COLOR_W  = plot_receiver_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               writeEn,
    input  logic [9:0]         x_in,
    input  logic [9:0]         y_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               clr_status,
    plot_receiver_if.master    mem,
    output logic               idle,
    output logic               overflow,
    output logic [7:0]         drop_count
);

    import plot_receiver_pkg::*;

    localparam int WIDTH = ADDR_W + COLOR_W;

    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [9:0] x,
                                                     input logic [9:0] y);
        logic [ADDR_W-1:0] xx;
        logic [ADDR_W-1:0] yy;
        xx = ADDR_W'(x);
        yy = ADDR_W'(y);
        if (SCREEN_W == 160)
            return (yy << 7) + (yy << 5) + xx;
        else
            return yy * ADDR_W'(SCREEN_W) + xx;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic               in_range;
    logic               vld_p1;
    logic               clip_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [COLOR_W-1:0] color_p1;

    logic               fifo_push;
    logic               fifo_pop;
    logic [WIDTH-1:0]   fifo_dout;
    logic               fifo_empty;
    logic               fifo_full;
    logic               lost;
    logic               drop_evt;

    drain_state_t       state;
    drain_state_t       state_next;
    logic               writing;

    assign in_range = (int'(x_in) < SCREEN_W) && (int'(y_in) < SCREEN_H);

    // ---- stage 1: input register, clip decision and address ----
    // The clip flag rides with the plot so that clip and overflow accounting
    // both happen at stage 2 and can never coincide in one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1  <= 1'b0;
            clip_p1 <= 1'b0;
        end else begin
            vld_p1  <= writeEn && in_range;
            clip_p1 <= writeEn && !in_range;
        end
    end

    always_ff @(posedge clk) begin
        addr_p1  <= pixel_addr(x_in, y_in);
        color_p1 <= color_in;
    end

    // ---- stage 2: FIFO push / overflow accounting ----
    assign fifo_pop  = writing && mem.mem_ready;
    assign fifo_push = vld_p1 && (!fifo_full || fifo_pop);
    assign lost      = vld_p1 && fifo_full && !fifo_pop;
    assign drop_evt  = clip_p1 || lost;

    plot_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    ({addr_p1, color_p1}),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (clr_status) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else begin
            if (lost)     overflow   <= 1'b1;
            if (drop_evt) drop_count <= sat_inc8(drop_count);
        end
    end

    // ---- stage 3: drain to framebuffer ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_next;
    end

    // Leaving S_IDLE on the push itself (not on non-empty) gives a two-cycle
    // writeEn-to-mem_we latency; S_WRITE therefore always has a valid head.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (fifo_push || !fifo_empty) state_next = S_WRITE;
            end
            S_WRITE: begin
                if (fifo_pop && !fifo_push &&
                    (u_fifo.rd_ptr + 1'b1) == u_fifo.wr_ptr)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign writing      = (state == S_WRITE);
    assign mem.mem_we   = writing;
    assign mem.mem_addr = writing ? fifo_dout[WIDTH-1:COLOR_W] : '0;
    assign mem.mem_data = writing ? fifo_dout[COLOR_W-1:0]     : '0;

    assign idle = !vld_p1 && fifo_empty;

endmodule
